// File: rtl/fifo_stream_pkg.sv
// Shared definitions for stages that sit directly downstream of the synchronous FIFO.
// Holds the downsizer state encoding and the width/slice helpers.
package fifo_stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int ratio(input int data_width, input int out_width);
        return data_width / out_width;
    endfunction

    // Maps the beat number within a word to the slice index inside that word.
    function automatic int slice_index(input int beat, input int n_slices, input logic msb_first);
        return msb_first ? (n_slices - 1 - beat) : beat;
    endfunction

endpackage

// File: rtl/fifo_stream_downsizer.sv
// Serialises FIFO words into RATIO narrow beats with valid/ready on both sides,
// grouping words into bursts of programmable length flagged by o_last.
module fifo_stream_downsizer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int WIDTH      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid_s,
    output logic                  o_ready_s,
    input  logic [DATA_WIDTH-1:0] i_datain,
    input  logic                  i_msb_first,
    input  logic [WIDTH-1:0]      i_burst_len,
    output logic                  o_valid_m,
    input  logic                  i_ready_m,
    output logic [OUT_WIDTH-1:0]  o_dataout,
    output logic                  o_last,
    output logic                  o_busy
);

    localparam int RATIO = ratio(DATA_WIDTH, OUT_WIDTH);
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("fifo_stream_downsizer: DATA_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
    end

    state_e                state, state_nx;
    logic [BW-1:0]         beat_cnt;
    logic [DATA_WIDTH-1:0] word_p1;
    logic                  msb_first_p1;
    logic                  last_p1;
    logic [WIDTH-1:0]      word_cnt;
    logic [WIDTH-1:0]      len_p1;
    logic [WIDTH-1:0]      len_eff;
    logic                  word_is_last;
    logic                  word_xfer;
    logic                  beat_xfer;
    logic                  on_last_beat;
    logic [BW-1:0]         sel;
    logic [OUT_WIDTH-1:0]  slices [RATIO];

    assign on_last_beat = (state == SHIFT) && (beat_cnt == LAST_BEAT);

    // Ready is combinational from the consumer so a new word loads on the last beat with no bubble.
    assign o_ready_s = !i_rst && ((state == IDLE) || (on_last_beat && i_ready_m));
    assign o_valid_m = (state == SHIFT);
    assign word_xfer = i_valid_s && o_ready_s;
    assign beat_xfer = o_valid_m && i_ready_m;

    // Burst length is sampled only on the first word of a burst; later changes wait for the next burst.
    assign len_eff      = (word_cnt == '0) ? i_burst_len : len_p1;
    assign word_is_last = (len_eff != '0) && (word_cnt == len_eff - WIDTH'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (word_xfer) state_nx = SHIFT;
            SHIFT:   if (beat_xfer && beat_cnt == LAST_BEAT && !word_xfer) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Word capture / beat advance stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat_cnt     <= '0;
            word_p1      <= '0;
            msb_first_p1 <= 1'b0;
            last_p1      <= 1'b0;
            word_cnt     <= '0;
            len_p1       <= '0;
        end else begin
            if (word_xfer) begin
                beat_cnt     <= '0;
                word_p1      <= i_datain;
                msb_first_p1 <= i_msb_first;
                last_p1      <= word_is_last;
                if (word_cnt == '0) begin
                    len_p1 <= i_burst_len;
                end
                if (len_eff == '0 || word_is_last) begin
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + WIDTH'(1);
                end
            end else if (beat_xfer) begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

    for (genvar i = 0; i < RATIO; i++) begin : g_slices
        assign slices[i] = word_p1[i*OUT_WIDTH +: OUT_WIDTH];
    end

    assign sel       = BW'(slice_index(int'(beat_cnt), RATIO, msb_first_p1));
    assign o_dataout = slices[sel];
    assign o_last    = on_last_beat && last_p1;
    assign o_busy    = (state == SHIFT) || (word_cnt != '0);

endmodule
